// File: rtl/issue_queue.sv
// Purpose : out-of-order issue queue; tag wakeup with dispatch bypass, oldest-first select via age matrix.
// Latency : dispatch→selectable next cycle (if ready); wakeup at edge N→selectable cycle N+1; select is combinational.
// Backpressure: disp_ready=0 when all entries valid; a selected entry is held until iss_ready; flush/reset drop everything.
// Ports   : clk/rst_n; disp_* dispatch handshake + operands; wk_tag/wk_valid wakeup buses;
//           iss_* issue handshake + operands; flush; ciq_count occupancy.
module issue_queue #(
  parameter int ISSUE_NUM = 4,
  parameter int PRF_WIDTH = 6,
  parameter int CIQ_DEPTH = 16,
  parameter int PAYLOAD_W = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [PRF_WIDTH-1:0]           disp_prs1,
  input  logic [PRF_WIDTH-1:0]           disp_prs2,
  input  logic                           disp_prs1_rdy,
  input  logic                           disp_prs2_rdy,
  input  logic [PRF_WIDTH-1:0]           disp_prd,
  input  logic                           disp_prd_v,
  input  logic [PAYLOAD_W-1:0]           disp_payload,
  input  logic [ISSUE_NUM*PRF_WIDTH-1:0] wk_tag,
  input  logic [ISSUE_NUM-1:0]           wk_valid,
  output logic                           iss_valid,
  input  logic                           iss_ready,
  output logic [PRF_WIDTH-1:0]           iss_prs1,
  output logic [PRF_WIDTH-1:0]           iss_prs2,
  output logic [PRF_WIDTH-1:0]           iss_prd,
  output logic                           iss_prd_v,
  output logic [PAYLOAD_W-1:0]           iss_payload,
  input  logic                           flush,
  output logic [$clog2(CIQ_DEPTH):0]     ciq_count
);

  localparam int CNT_W = $clog2(CIQ_DEPTH) + 1;

  logic [CIQ_DEPTH-1:0] valid, rdy1, rdy2, prd_v_q;
  logic [PRF_WIDTH-1:0] prs1_q [CIQ_DEPTH];
  logic [PRF_WIDTH-1:0] prs2_q [CIQ_DEPTH];
  logic [PRF_WIDTH-1:0] prd_q  [CIQ_DEPTH];
  logic [PAYLOAD_W-1:0] pay_q  [CIQ_DEPTH];
  // age[i][j]=1 means entry j is older than entry i
  logic [CIQ_DEPTH-1:0] age    [CIQ_DEPTH];

  logic [CIQ_DEPTH-1:0] eligible, sel, alloc_oh, hit1, hit2;
  logic                 disp_hit1, disp_hit2, found, disp_fire, iss_fire;

  function automatic logic tag_hit(input logic [PRF_WIDTH-1:0] t,
                                   input logic [ISSUE_NUM-1:0] v,
                                   input logic [ISSUE_NUM*PRF_WIDTH-1:0] tags);
    logic h;
    h = 1'b0;
    for (int j = 0; j < ISSUE_NUM; j++) begin
      if (v[j] && (tags[j*PRF_WIDTH +: PRF_WIDTH] == t)) h = 1'b1;
    end
    return h;
  endfunction

  always_comb begin
    disp_hit1 = tag_hit(disp_prs1, wk_valid, wk_tag);
    disp_hit2 = tag_hit(disp_prs2, wk_valid, wk_tag);
    eligible  = valid & rdy1 & rdy2;
    alloc_oh  = '0;
    found     = 1'b0;
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      hit1[i] = tag_hit(prs1_q[i], wk_valid, wk_tag);
      hit2[i] = tag_hit(prs2_q[i], wk_valid, wk_tag);
      // an eligible entry wins only if no other eligible entry is older
      sel[i]  = eligible[i] & ~|(age[i] & eligible);
      if (!valid[i] && !found) begin
        alloc_oh[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    iss_prs1    = '0;
    iss_prs2    = '0;
    iss_prd     = '0;
    iss_prd_v   = 1'b0;
    iss_payload = '0;
    // AND-OR mux: outputs are naturally zero when nothing is selected
    for (int i = 0; i < CIQ_DEPTH; i++) begin
      if (sel[i]) begin
        iss_prs1    = iss_prs1 | prs1_q[i];
        iss_prs2    = iss_prs2 | prs2_q[i];
        iss_prd     = iss_prd | prd_q[i];
        iss_prd_v   = iss_prd_v | prd_v_q[i];
        iss_payload = iss_payload | pay_q[i];
      end
    end
  end

  assign iss_valid  = |sel;
  assign disp_ready = ~&valid;
  assign disp_fire  = disp_valid & disp_ready;
  assign iss_fire   = iss_valid & iss_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= '0;
      rdy1      <= '0;
      rdy2      <= '0;
      prd_v_q   <= '0;
      ciq_count <= '0;
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        prs1_q[i] <= '0;
        prs2_q[i] <= '0;
        prd_q[i]  <= '0;
        pay_q[i]  <= '0;
        age[i]    <= '0;
      end
    end else if (flush) begin
      valid     <= '0;
      rdy1      <= '0;
      rdy2      <= '0;
      ciq_count <= '0;
      for (int i = 0; i < CIQ_DEPTH; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < CIQ_DEPTH; i++) begin
        if (valid[i]) begin
          if (hit1[i]) rdy1[i] <= 1'b1;
          if (hit2[i]) rdy2[i] <= 1'b1;
        end
        if (iss_fire && sel[i]) valid[i] <= 1'b0;
        if (disp_fire) begin
          if (alloc_oh[i]) begin
            valid[i]   <= 1'b1;
            prs1_q[i]  <= disp_prs1;
            prs2_q[i]  <= disp_prs2;
            rdy1[i]    <= disp_prs1_rdy | disp_hit1;
            rdy2[i]    <= disp_prs2_rdy | disp_hit2;
            prd_q[i]   <= disp_prd;
            prd_v_q[i] <= disp_prd_v;
            pay_q[i]   <= disp_payload;
            // everything currently valid is older than the newcomer
            age[i]     <= valid;
          end else begin
            age[i]     <= age[i] & ~alloc_oh;
          end
        end
      end
      ciq_count <= ciq_count + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
module tb_issue_queue;
  localparam int NI = 4;
  localparam int PW = 6;
  localparam int D  = 16;
  localparam int PL = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          disp_valid, disp_ready;
  logic [PW-1:0] disp_prs1, disp_prs2, disp_prd;
  logic          disp_prs1_rdy, disp_prs2_rdy, disp_prd_v;
  logic [PL-1:0] disp_payload;
  logic [NI*PW-1:0] wk_tag;
  logic [NI-1:0] wk_valid;
  logic          iss_valid, iss_ready;
  logic [PW-1:0] iss_prs1, iss_prs2, iss_prd;
  logic          iss_prd_v;
  logic [PL-1:0] iss_payload;
  logic          flush;
  logic [$clog2(D):0] ciq_count;

  issue_queue #(.ISSUE_NUM(NI), .PRF_WIDTH(PW), .CIQ_DEPTH(D), .PAYLOAD_W(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_prs1(disp_prs1), .disp_prs2(disp_prs2),
    .disp_prs1_rdy(disp_prs1_rdy), .disp_prs2_rdy(disp_prs2_rdy),
    .disp_prd(disp_prd), .disp_prd_v(disp_prd_v), .disp_payload(disp_payload),
    .wk_tag(wk_tag), .wk_valid(wk_valid),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_prs1(iss_prs1), .iss_prs2(iss_prs2), .iss_prd(iss_prd),
    .iss_prd_v(iss_prd_v), .iss_payload(iss_payload),
    .flush(flush), .ciq_count(ciq_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] prs1;
    logic          r1;
    logic [PW-1:0] prs2;
    logic          r2;
    logic [PW-1:0] prd;
    logic          prd_v;
    logic [PL-1:0] payload;
  } ent_t;

  // reference: entries kept in dispatch order, index 0 is the oldest
  ent_t m_q[$];
  ent_t exp_iss[$];
  int   m_sel;
  int   exp_count;
  logic exp_drdy, exp_ivalid;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic bit m_hit(input logic [PW-1:0] t);
    for (int j = 0; j < NI; j++)
      if (wk_valid[j] && wk_tag[j*PW +: PW] == t) return 1'b1;
    return 1'b0;
  endfunction

  // expected outputs for the current cycle, given current inputs
  task automatic predict();
    m_sel = -1;
    for (int i = 0; i < m_q.size(); i++)
      if (m_sel < 0 && m_q[i].r1 && m_q[i].r2) m_sel = i;
    exp_ivalid = (m_sel >= 0);
    exp_count  = m_q.size();
    exp_drdy   = (m_q.size() < D);
    if (exp_ivalid && iss_ready) exp_iss.push_back(m_q[m_sel]);
  endtask

  // apply the effect of the rising edge that just happened
  task automatic model_edge();
    ent_t e;
    int   old_size;
    old_size = m_q.size();
    if (!rst_n || flush) begin
      m_q.delete();
    end else begin
      e.prs1 = disp_prs1; e.prs2 = disp_prs2;
      e.r1 = disp_prs1_rdy | m_hit(disp_prs1);
      e.r2 = disp_prs2_rdy | m_hit(disp_prs2);
      e.prd = disp_prd; e.prd_v = disp_prd_v; e.payload = disp_payload;
      for (int i = 0; i < m_q.size(); i++) begin
        ent_t x;
        x = m_q[i];
        if (m_hit(x.prs1)) x.r1 = 1'b1;
        if (m_hit(x.prs2)) x.r2 = 1'b1;
        m_q[i] = x;
      end
      if (m_sel >= 0 && iss_ready) m_q.delete(m_sel);
      if (disp_valid && old_size < D) m_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic step();
    predict();
    tick();
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    wk_valid   = '0;
    flush      = 1'b0;
  endtask

  task automatic set_disp(input logic [PW-1:0] p1, input logic r1,
                          input logic [PW-1:0] p2, input logic r2, input logic [PL-1:0] pl);
    disp_valid    = 1'b1;
    disp_prs1     = p1;
    disp_prs1_rdy = r1;
    disp_prs2     = p2;
    disp_prs2_rdy = r2;
    disp_prd      = PW'($urandom_range(0, 63));
    disp_prd_v    = 1'($urandom_range(0, 1));
    disp_payload  = pl;
  endtask

  task automatic wake(input int bus, input logic [PW-1:0] t);
    wk_valid[bus]         = 1'b1;
    wk_tag[bus*PW +: PW]  = t;
  endtask

  // monitor: status every cycle, pops expected issue on every handshake
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      chk("ciq_count", 64'(ciq_count), 64'(exp_count));
      chk("disp_ready", 64'(disp_ready), 64'(exp_drdy));
      chk("iss_valid", 64'(iss_valid), 64'(exp_ivalid));
      if (iss_valid && iss_ready) begin
        if (exp_iss.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_issue: got payload %0h expected no issue", iss_payload);
        end else begin
          e = exp_iss.pop_front();
          chk("iss_prs1", 64'(iss_prs1), 64'(e.prs1));
          chk("iss_prs2", 64'(iss_prs2), 64'(e.prs2));
          chk("iss_prd", 64'(iss_prd), 64'(e.prd));
          chk("iss_prd_v", 64'(iss_prd_v), 64'(e.prd_v));
          chk("iss_payload", 64'(iss_payload), 64'(e.payload));
        end
      end else if (!iss_valid) begin
        chk("iss_idle_zero", 64'({iss_prs1, iss_prs2, iss_prd, iss_prd_v, iss_payload}), 64'd0);
      end
    end
  end

  initial begin
    rst_n = 1'b0; iss_ready = 1'b0; wk_tag = '0;
    disp_prs1 = '0; disp_prs2 = '0; disp_prs1_rdy = 1'b0; disp_prs2_rdy = 1'b0;
    disp_prd = '0; disp_prd_v = 1'b0; disp_payload = '0;
    idle();
    exp_count = 0; exp_drdy = 1'b1; exp_ivalid = 1'b0; m_sel = -1;
    predict();
    @(negedge clk);
    chk("rst_count", 64'(ciq_count), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // wakeup at edge N, issue in cycle N+1
    iss_ready = 1'b1;
    set_disp(6'd5, 1'b0, 6'd7, 1'b1, 32'h1111_0001); step();
    idle(); wake(2, 6'd5); predict();
    @(negedge clk); chk("wk_not_same_cycle", 64'(iss_valid), 64'd0);
    tick();
    idle(); predict();
    @(negedge clk); chk("wk_iss_valid", 64'(iss_valid), 64'd1); chk("wk_iss_prs1", 64'(iss_prs1), 64'd5);
    tick();

    // dispatch bypass
    set_disp(6'd9, 1'b0, 6'd1, 1'b1, 32'h2222_0002); wake(0, 6'd9); step();
    idle(); predict();
    @(negedge clk); chk("bypass_iss_valid", 64'(iss_valid), 64'd1); chk("bypass_prs1", 64'(iss_prs1), 64'd9);
    tick();

    // age order: A(3) B(4) C(3), broadcast 3 once
    idle(); set_disp(6'd3, 1'b0, 6'd0, 1'b1, 32'hAAAA); step();
    idle(); set_disp(6'd4, 1'b0, 6'd0, 1'b1, 32'hBBBB); step();
    idle(); set_disp(6'd3, 1'b0, 6'd0, 1'b1, 32'hCCCC); step();
    idle(); wake(1, 6'd3); step();
    idle(); predict(); @(negedge clk); chk("order_first_A", 64'(iss_payload), 64'hAAAA); tick();
    predict(); @(negedge clk); chk("order_second_C", 64'(iss_payload), 64'hCCCC); tick();
    predict(); @(negedge clk); chk("order_B_stuck", 64'(iss_valid), 64'd0); tick();

    // flush with concurrent dispatch on 6 entries
    for (int i = 0; i < 5; i++) begin
      idle(); set_disp(PW'(20 + i), 1'b0, PW'(20 + i), 1'b0, 32'(i)); step();
    end
    idle(); predict(); @(negedge clk); chk("pre_flush_count", 64'(ciq_count), 64'd6); tick();
    set_disp(6'd1, 1'b1, 6'd1, 1'b1, 32'hDEAD); flush = 1'b1; step();
    idle(); predict(); @(negedge clk);
    chk("flush_count", 64'(ciq_count), 64'd0); chk("flush_iss_valid", 64'(iss_valid), 64'd0);
    tick();

    // fill completely, then issue + dispatch in the same cycle
    iss_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      idle(); set_disp(PW'(32 + i), 1'b0, PW'(32 + i), 1'b0, 32'h100 + 32'(i)); step();
    end
    idle(); predict(); @(negedge clk);
    chk("full_disp_ready", 64'(disp_ready), 64'd0); chk("full_count", 64'(ciq_count), 64'd16);
    tick();
    idle(); wake(3, 6'd37); step();
    iss_ready = 1'b1; set_disp(6'd50, 1'b0, 6'd50, 1'b0, 32'h5050); predict(); @(negedge clk);
    chk("full_issue_valid", 64'(iss_valid), 64'd1); chk("full_no_accept", 64'(disp_ready), 64'd0);
    tick();
    iss_ready = 1'b0; predict(); @(negedge clk);
    chk("freed_disp_ready", 64'(disp_ready), 64'd1); chk("freed_count", 64'(ciq_count), 64'd15);
    tick();
    idle(); predict(); @(negedge clk); chk("refill_count", 64'(ciq_count), 64'd16); tick();
    flush = 1'b1; step(); idle();

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      idle(); set_disp(PW'(i), 1'b1, PW'(i), 1'b1, 32'h700 + 32'(i)); step();
    end
    idle(); set_disp(6'd2, 1'b1, 6'd2, 1'b1, 32'h7777); predict();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(ciq_count), 64'd0);
    chk("arst_iss_valid", 64'(iss_valid), 64'd0);
    chk("arst_disp_ready", 64'(disp_ready), 64'd1);
    m_q.delete();
    idle(); predict();
    tick(); tick();
    rst_n = 1'b1;
    set_disp(6'd11, 1'b0, 6'd12, 1'b0, 32'h8888); step();
    idle(); predict(); @(negedge clk); chk("first_disp_after_rst", 64'(ciq_count), 64'd1); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        set_disp(PW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0),
                 PW'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0), $urandom);
      for (int j = 0; j < NI; j++) begin
        wk_tag[j*PW +: PW] = PW'($urandom_range(0, 15));
        wk_valid[j]        = ($urandom_range(0, 2) == 0);
      end
      iss_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      step();
    end

    idle(); iss_ready = 1'b0; predict();
    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_iss.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
